// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID pipeline register, stall / branch / flush handling.
// Define FETCH_HALT_EN to stop fetching once the PC would leave the PROG_LEN-word program.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PROG_LEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [25:0]     branch_offset,
  output logic [PC_W-1:0] pc_out,
  input  logic [31:0]     inst_in,
  output logic [31:0]     if_id_inst,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_inst_q, if_id_inst_d;
  logic            if_id_valid_q, if_id_valid_d;

  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc_seq;
  logic            seq_past_end;
  logic            target_past_end;

  // Sign-extend (or truncate) the 26-bit word offset to the PC width.
  genvar gi;
  generate
    for (gi = 0; gi < PC_W; gi++) begin : g_sext
      if (gi < 26) begin : g_bit
        assign offset_ext[gi] = branch_offset[gi];
      end else begin : g_sign
        assign offset_ext[gi] = branch_offset[25];
      end
    end
    if (PC_W < 26) begin : g_trunc
      logic unused_offset_hi;
      assign unused_offset_hi = ^branch_offset[25:PC_W];
    end
  endgenerate

  assign branch_target = if_id_pc_q + offset_ext;

`ifdef FETCH_HALT_EN
  localparam logic [PC_W:0] LIMIT = (PC_W + 1)'(PROG_LEN);

  // The end-of-program test uses the unwrapped increment so a program that
  // fills the whole address space still halts instead of wrapping to 0.
  logic [PC_W:0] pc_seq_wide;
  logic          halted_q;

  assign pc_seq_wide     = {1'b0, pc_q} + (PC_W + 1)'(1);
  assign pc_seq          = pc_seq_wide[PC_W-1:0];
  assign seq_past_end    = (pc_seq_wide >= LIMIT);
  assign target_past_end = ({1'b0, branch_target} >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= (state_q == ST_HALT);
    end
  end

  assign halted = halted_q;
`else
  localparam int unused_prog_len = PROG_LEN;

  assign pc_seq          = pc_q + PC_W'(1);
  assign seq_past_end    = 1'b0;
  assign target_past_end = 1'b0;
  assign halted          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          if_id_inst_d  = '0;
          if_id_pc_d    = '0;
          if_id_valid_d = 1'b0;
          if (target_past_end) begin
            state_d = ST_HALT;
          end else begin
            pc_d = branch_target;
          end
        end else if (!stall) begin
          if_id_inst_d  = inst_in;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
          if (seq_past_end) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      ST_HALT: begin
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_inst_q  <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;

`ifndef SYNTHESIS
  // A redirect against a bubble is still honoured, but usually means decode is confused.
  always @(posedge clk) begin
    if (!reset && state_q == ST_RUN) begin
      assert (!(branch_taken && !if_id_valid_q))
        else $warning("fetch_stage: branch_taken while IF/ID holds a bubble");
    end
  end
`endif

endmodule
